// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK link blocks: BER checker defaults and
// the alignment-search state encoding.
package qpsk_pkg;

    localparam int REF_DEPTH_DEF = 512;
    localparam int WINDOW_DEF    = 511;
    localparam int CNT_W_DEF     = 64;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } ber_state_t;

endpackage

// File: rtl/ber_delay_line.sv
// Reference-bit delay line with a tap mux: sel=0 passes din straight through,
// sel=k returns the bit shifted in k strobes earlier.
module ber_delay_line #(
    parameter int DEPTH = 512,
    parameter int SEL_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             din,
    input  logic [SEL_W-1:0] sel,
    output logic             dout
);

    // Only DEPTH-1 stored entries are ever selectable; tap 0 is din itself.
    logic [DEPTH-2:0] line;
    logic [DEPTH-1:0] taps;

    assign taps = {line, din};
    assign dout = taps[sel];

    always_ff @(posedge clk) begin
        if (reset) begin
            line <= '0;
        end else if (shift) begin
            line <= taps[DEPTH-2:0];
        end
    end

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker: searches reference alignment offsets for an
// error-free window, then counts bits and errors at the locked offset.
module ber_checker
    import qpsk_pkg::*;
#(
    parameter int REF_DEPTH = REF_DEPTH_DEF,
    parameter int WINDOW    = WINDOW_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_enable,
    input  logic                         i_rx_bit,
    input  logic                         i_ref_bit,
    input  logic                         i_clear,
    output logic                         o_locked,
    output logic [$clog2(REF_DEPTH)-1:0] o_offset,
    output logic [CNT_W-1:0]             o_err_count,
    output logic [CNT_W-1:0]             o_bit_count
);

    localparam int OFF_W = $clog2(REF_DEPTH);
    localparam int WIN_W = $clog2(WINDOW + 1);

    ber_state_t       state_q, state_d;
    logic [OFF_W-1:0] offset_q, offset_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0] win_err_q, win_err_d;
    logic [WIN_W-1:0] win_err_sum;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] bit_q, bit_d;
    logic             cmp_bit;
    logic             mismatch;

    // The delay line shifts on every strobe, even one dropped by i_clear.
    ber_delay_line #(
        .DEPTH (REF_DEPTH),
        .SEL_W (OFF_W)
    ) u_delay_line (
        .clk   (clk),
        .reset (reset),
        .shift (i_enable),
        .din   (i_ref_bit),
        .sel   (offset_q),
        .dout  (cmp_bit)
    );

    assign mismatch    = i_rx_bit ^ cmp_bit;
    assign win_err_sum = win_err_q + WIN_W'(mismatch);

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        err_d     = err_q;
        bit_d     = bit_q;

        if (i_clear) begin
            state_d   = SEARCH;
            offset_d  = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            err_d     = '0;
            bit_d     = '0;
        end else if (i_enable) begin
            case (state_q)
                SEARCH: begin
                    if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                        if (win_err_sum == '0) begin
                            state_d = LOCKED;
                        end else if (offset_q == OFF_W'(REF_DEPTH - 1)) begin
                            offset_d = '0;
                        end else begin
                            offset_d = offset_q + 1'b1;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q + 1'b1;
                        win_err_d = win_err_sum;
                    end
                end
                LOCKED: begin
                    if (bit_q != '1) begin
                        bit_d = bit_q + 1'b1;
                    end
                    if (mismatch && (err_q != '1)) begin
                        err_d = err_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= SEARCH;
            offset_q  <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            err_q     <= '0;
            bit_q     <= '0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            err_q     <= err_d;
            bit_q     <= bit_d;
        end
    end

    assign o_locked    = (state_q == LOCKED);
    assign o_offset    = offset_q;
    assign o_err_count = err_q;
    assign o_bit_count = bit_q;

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 SHALL have parameter REF_DEPTH, default 512, meaning depth of the reference-bit delay line and number of candidate alignment offsets (0..REF_DEPTH-1).
REQ-002 SHALL have parameter WINDOW, default 511, meaning number of symbols compared per candidate offset during search.
REQ-003 SHALL have parameter CNT_W, default 64, meaning width of the error and bit counters.
REQ-004 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port i_enable, input, 1, symbol strobe; one pulse per decided symbol from the rx filter/slicer.
REQ-007 SHALL have port i_rx_bit, input, 1, received decided bit (rx o_rx), valid when i_enable=1.
REQ-008 SHALL have port i_ref_bit, input, 1, local PRBS reference bit, valid when i_enable=1.
REQ-009 SHALL have port i_clear, input, 1, restarts alignment search and zeroes the counters.
REQ-010 SHALL have port o_locked, output, 1, high while in LOCKED state.
REQ-011 SHALL have port o_offset, output, log2(REF_DEPTH), current candidate or locked alignment offset.
REQ-012 SHALL have port o_err_count, output, CNT_W, bit errors accumulated while locked.
REQ-013 SHALL have port o_bit_count, output, CNT_W, bits compared while locked.

Function
REQ-014 SHALL, on each i_enable, shift i_ref_bit into the delay line; entry k holds the reference bit from k+1 strobes earlier.
REQ-015 SHALL define the compare bit as i_ref_bit when o_offset=0, else delay-line entry o_offset-1 (value before this strobe's shift); mismatch = i_rx_bit XOR compare bit.
REQ-016 SHALL implement two states: SEARCH and LOCKED; reset and i_clear enter SEARCH.
REQ-017 SHALL, in SEARCH on each i_enable, increment a window counter (0..WINDOW-1) and accumulate mismatches into a window error count.
REQ-018 SHALL, on the strobe where the window counter equals WINDOW-1, enter LOCKED if window errors including this strobe equal 0; otherwise advance o_offset by 1 (wrapping REF_DEPTH-1 -> 0) and zero the window counter and window errors.
REQ-019 SHALL hold o_offset constant while LOCKED.
REQ-020 SHALL, in LOCKED on each i_enable, increment o_bit_count by 1 and o_err_count by mismatch; the transition strobe itself is not counted.
REQ-021 SHALL saturate each counter at all-ones; no wrap.
REQ-022 SHALL keep all state unchanged on clocks with i_enable=0.
REQ-023 SHALL give i_clear priority over a simultaneous i_enable: the strobe is dropped from counters and window, but the delay line still shifts.
REQ-024 SHALL register all outputs; effect of a strobe visible on the clock after the sampling edge (latency 1).
REQ-025 SHALL not leave LOCKED on errors; only i_clear or reset re-enters SEARCH.

Reset
REQ-026 SHALL, on reset, set state SEARCH, o_locked=0, o_offset=0, o_err_count=0, o_bit_count=0, window counter and window errors 0, delay line all zeros.
REQ-027 SHALL let reset override i_enable and i_clear in the same cycle, including mid-window and while LOCKED.
REQ-028 SHALL, on i_clear, apply the REQ-026 values except the delay line, which keeps its contents.

Structure
REQ-029 SHALL take REF_DEPTH, WINDOW, CNT_W defaults and the SEARCH/LOCKED state encoding from shared package qpsk_pkg.
REQ-030 SHALL place the delay line and offset mux in sub-module ber_delay_line (ports clk, reset, shift, din, sel, dout).

Verification
REQ-031 SHALL verify: PRBS9 ref, rx = ref delayed 37 strobes, no errors -> o_locked=1 after 38x511 strobes, o_offset=37, o_err_count=0.
REQ-032 SHALL verify: locked at offset 37, invert every 100th rx bit over 10000 strobes -> o_bit_count=10000, o_err_count=100.
REQ-033 SHALL verify: rx tied to 0, ref PRBS9 -> o_offset wraps 511->0, o_locked stays 0.
REQ-034 SHALL verify: i_clear asserted with i_enable while locked -> next cycle o_locked=0, o_offset=0, counters 0; relock at same delay.
REQ-035 SHALL verify: reset pulsed mid-window (window counter 200) -> all outputs zero next cycle; i_enable gaps of 0..7 clocks do not change results of REQ-031.
